apb_req_master: RTL and testbench



---
 rtl/apb_req_master_if.sv | 44 ++++
 rtl/apb_req_master.sv | 110 +++++++++++
 tb/tb_apb_req_master.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_req_master_if.sv
// apb_req_master_if: groups the core-side request/grant/response port and the APB master
// signal set of apb_req_master into one bundle.
//   master modport : the bridge's view (drives gnt/rvalid/rdata/err and the APB outputs)
//   slave modport  : the environment's view (core + APB slave side)
// Signals:
//   req_i, we_i, addr_i, wdata_i         core request
//   gnt_o, rvalid_o, rdata_o, err_o      core grant / response
//   paddr_o, pwdata_o, pwrite_o,
//   psel_o, penable_o                    APB master outputs
//   prdata_i, pready_i, pslverr_i        APB slave responses
interface apb_req_master_if #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32
) ();
    logic                      req_i;
    logic                      we_i;
    logic [APB_ADDR_WIDTH-1:0] addr_i;
    logic [APB_DATA_WIDTH-1:0] wdata_i;
    logic                      gnt_o;
    logic                      rvalid_o;
    logic [APB_DATA_WIDTH-1:0] rdata_o;
    logic                      err_o;

    logic [APB_ADDR_WIDTH-1:0] paddr_o;
    logic [APB_DATA_WIDTH-1:0] pwdata_o;
    logic                      pwrite_o;
    logic                      psel_o;
    logic                      penable_o;
    logic [APB_DATA_WIDTH-1:0] prdata_i;
    logic                      pready_i;
    logic                      pslverr_i;

    modport master (
        input  req_i, we_i, addr_i, wdata_i, prdata_i, pready_i, pslverr_i,
        output gnt_o, rvalid_o, rdata_o, err_o,
        output paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );

    modport slave (
        output req_i, we_i, addr_i, wdata_i, prdata_i, pready_i, pslverr_i,
        input  gnt_o, rvalid_o, rdata_o, err_o,
        input  paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
    );
endinterface

// File: rtl/apb_req_master.sv
// apb_req_master: bridges a core request/grant/response port onto one APB master port.
// Runs the APB SETUP/ACCESS phases, honours wait states and pslverr, and returns a
// single-cycle registered response pulse (rvalid_o with rdata_o/err_o).
// Ports:
//   HCLK     clock
//   HRESETn  synchronous active-low reset
//   bus      apb_req_master_if.master (core handshake + APB master signals)
// Optional feature: define APB_MASTER_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES cycles without pready_i (response with err_o = 1).
module apb_req_master #(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic              HCLK,
    input logic              HRESETn,
    apb_req_master_if.master bus
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e state_q;
    logic   access_done;
    logic   timeout;

    assign access_done   = (state_q == StAccess) && bus.pready_i;
    // Grant either from IDLE or in the completing ACCESS cycle (back-to-back).
    assign bus.gnt_o     = bus.req_i && ((state_q == StIdle) || access_done);
    assign bus.psel_o    = (state_q != StIdle);
    assign bus.penable_o = (state_q == StAccess);

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q;

    // cnt_q holds the 1-based index of the current ACCESS cycle.
    assign timeout = (state_q == StAccess) && !bus.pready_i &&
                     (cnt_q == CntW'(TIMEOUT_CYCLES));
`else
    logic unused_timeout_cycles;

    assign timeout               = 1'b0;
    assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q      <= StIdle;
            bus.paddr_o  <= {APB_ADDR_WIDTH{1'b0}};
            bus.pwdata_o <= {APB_DATA_WIDTH{1'b0}};
            bus.pwrite_o <= 1'b0;
            bus.rvalid_o <= 1'b0;
            bus.rdata_o  <= {APB_DATA_WIDTH{1'b0}};
            bus.err_o    <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            // Response outputs are a one-cycle pulse.
            bus.rvalid_o <= 1'b0;
            bus.rdata_o  <= {APB_DATA_WIDTH{1'b0}};
            bus.err_o    <= 1'b0;

            if (access_done) begin
                bus.rvalid_o <= 1'b1;
                bus.err_o    <= bus.pslverr_i;
                bus.rdata_o  <= bus.pwrite_o ? {APB_DATA_WIDTH{1'b0}} : bus.prdata_i;
            end else if (timeout) begin
                bus.rvalid_o <= 1'b1;
                bus.err_o    <= 1'b1;
            end

            // APB address/data/direction stay stable until the next grant.
            if (bus.gnt_o) begin
                bus.paddr_o  <= bus.addr_i;
                bus.pwdata_o <= bus.wdata_i;
                bus.pwrite_o <= bus.we_i;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.gnt_o) begin
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    state_q <= StAccess;
`ifdef APB_MASTER_TIMEOUT_EN
                    cnt_q   <= CntW'(1);
`endif
                end
                StAccess: begin
                    if (access_done) begin
                        state_q <= bus.gnt_o ? StSetup : StIdle;
                    end else if (timeout) begin
                        state_q <= StIdle;
                    end else begin
`ifdef APB_MASTER_TIMEOUT_EN
                        cnt_q   <= cnt_q + CntW'(1);
`endif
                        state_q <= StAccess;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_master.sv
module tb_apb_req_master;

    localparam logic [31:0] A_ADDR  = 32'h1A10_2000;
    localparam logic [31:0] A_DATA  = 32'h0000_00A5;
    localparam logic [31:0] B_ADDR  = 32'h1A10_5004;
    localparam logic [31:0] RD_B    = 32'hCAFE_0001;
    localparam logic [31:0] C1_ADDR = 32'h1A10_6000;
    localparam logic [31:0] C2_ADDR = 32'h1A10_6004;
    localparam logic [31:0] C3_ADDR = 32'h1A10_6008;
    localparam logic [31:0] D1      = 32'h1111_1111;
    localparam logic [31:0] D2      = 32'h2222_2222;
    localparam logic [31:0] D3      = 32'h3333_3333;
    localparam logic [31:0] E_ADDR  = 32'h1A10_3008;
    localparam logic [31:0] RD_E    = 32'h1234_5678;
    localparam int          NVEC    = 27;

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        pready;
        logic [31:0] prdata;
        logic        pslverr;
        logic        gnt;
        logic        psel;
        logic        penable;
        logic        pwrite;
        logic [31:0] paddr;
        logic [31:0] pwdata;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    logic HCLK;
    logic HRESETn;
    int   n_tests;
    int   n_fail;
    vec_t vecs [NVEC];

    apb_req_master_if #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32)) bus ();

    apb_req_master #(
        .APB_ADDR_WIDTH(32),
        .APB_DATA_WIDTH(32),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .HCLK   (HCLK),
        .HRESETn(HRESETn),
        .bus    (bus.master)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic req, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic pready,
                         input logic [31:0] prdata, input logic pslverr);
        bus.req_i     = req;
        bus.we_i      = we;
        bus.addr_i    = addr;
        bus.wdata_i   = wdata;
        bus.pready_i  = pready;
        bus.prdata_i  = prdata;
        bus.pslverr_i = pslverr;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " psel"}, {31'd0, bus.psel_o}, 32'd0);
        chk({tag, " penable"}, {31'd0, bus.penable_o}, 32'd0);
        chk({tag, " pwrite"}, {31'd0, bus.pwrite_o}, 32'd0);
        chk({tag, " paddr"}, bus.paddr_o, 32'd0);
        chk({tag, " pwdata"}, bus.pwdata_o, 32'd0);
        chk({tag, " rvalid"}, {31'd0, bus.rvalid_o}, 32'd0);
        chk({tag, " rdata"}, bus.rdata_o, 32'd0);
        chk({tag, " err"}, {31'd0, bus.err_o}, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        // req we addr wdata pready prdata pslverr | gnt psel pen pwrite paddr pwdata rvalid rdata err
        vecs[0]  = '{1, 1, A_ADDR, A_DATA, 1, 0, 0,    1, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, A_ADDR, A_DATA, 1, 0, 0,    0, 1, 0, 1, A_ADDR, A_DATA, 0, 0, 0};
        vecs[2]  = '{0, 1, A_ADDR, A_DATA, 1, 0, 0,    0, 1, 1, 1, A_ADDR, A_DATA, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 0, 1, 0, 0,              0, 0, 0, 1, A_ADDR, A_DATA, 1, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 1, A_ADDR, A_DATA, 0, 0, 0};
        vecs[5]  = '{1, 0, B_ADDR, A_DATA, 0, 0, 0,    1, 0, 0, 1, A_ADDR, A_DATA, 0, 0, 0};
        vecs[6]  = '{0, 0, B_ADDR, A_DATA, 0, 0, 0,    0, 1, 0, 0, B_ADDR, A_DATA, 0, 0, 0};
        vecs[7]  = '{0, 0, B_ADDR, A_DATA, 0, 0, 0,    0, 1, 1, 0, B_ADDR, A_DATA, 0, 0, 0};
        vecs[8]  = '{0, 0, B_ADDR, A_DATA, 0, 0, 0,    0, 1, 1, 0, B_ADDR, A_DATA, 0, 0, 0};
        vecs[9]  = '{0, 0, B_ADDR, A_DATA, 0, 0, 0,    0, 1, 1, 0, B_ADDR, A_DATA, 0, 0, 0};
        vecs[10] = '{0, 0, B_ADDR, A_DATA, 1, RD_B, 0, 0, 1, 1, 0, B_ADDR, A_DATA, 0, 0, 0};
        vecs[11] = '{0, 0, 0, 0, 1, 0, 0,              0, 0, 0, 0, B_ADDR, A_DATA, 1, RD_B, 0};
        vecs[12] = '{0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, B_ADDR, A_DATA, 0, 0, 0};
        vecs[13] = '{1, 1, C1_ADDR, D1, 1, 0, 0,       1, 0, 0, 0, B_ADDR, A_DATA, 0, 0, 0};
        vecs[14] = '{1, 1, C2_ADDR, D2, 1, 0, 0,       0, 1, 0, 1, C1_ADDR, D1, 0, 0, 0};
        vecs[15] = '{1, 1, C2_ADDR, D2, 1, 0, 0,       1, 1, 1, 1, C1_ADDR, D1, 0, 0, 0};
        vecs[16] = '{1, 1, C3_ADDR, D3, 1, 0, 0,       0, 1, 0, 1, C2_ADDR, D2, 1, 0, 0};
        vecs[17] = '{1, 1, C3_ADDR, D3, 1, 0, 0,       1, 1, 1, 1, C2_ADDR, D2, 0, 0, 0};
        vecs[18] = '{0, 1, C3_ADDR, D3, 1, 0, 0,       0, 1, 0, 1, C3_ADDR, D3, 1, 0, 0};
        vecs[19] = '{0, 1, C3_ADDR, D3, 1, 0, 0,       0, 1, 1, 1, C3_ADDR, D3, 0, 0, 0};
        vecs[20] = '{0, 0, 0, 0, 1, 0, 0,              0, 0, 0, 1, C3_ADDR, D3, 1, 0, 0};
        vecs[21] = '{0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 1, C3_ADDR, D3, 0, 0, 0};
        vecs[22] = '{1, 0, E_ADDR, D3, 0, 0, 0,        1, 0, 0, 1, C3_ADDR, D3, 0, 0, 0};
        vecs[23] = '{0, 0, E_ADDR, D3, 0, 0, 0,        0, 1, 0, 0, E_ADDR, D3, 0, 0, 0};
        vecs[24] = '{0, 0, E_ADDR, D3, 1, RD_E, 1,     0, 1, 1, 0, E_ADDR, D3, 0, 0, 0};
        vecs[25] = '{0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, E_ADDR, D3, 1, RD_E, 1};
        vecs[26] = '{0, 0, 0, 0, 0, 0, 0,              0, 0, 0, 0, E_ADDR, D3, 0, 0, 0};

        // Reset
        HRESETn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        #3;
        chk_all_zero("reset");
        chk("reset gnt", {31'd0, bus.gnt_o}, 32'd0);
        tick();
        HRESETn = 1'b1;

        // Table: zero-wait write, 3-wait read, back-to-back writes, slave error
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].pready,
                  vecs[i].prdata, vecs[i].pslverr);
            #3;
            chk($sformatf("vec%0d gnt", i), {31'd0, bus.gnt_o}, {31'd0, vecs[i].gnt});
            chk($sformatf("vec%0d psel", i), {31'd0, bus.psel_o}, {31'd0, vecs[i].psel});
            chk($sformatf("vec%0d penable", i), {31'd0, bus.penable_o},
                {31'd0, vecs[i].penable});
            chk($sformatf("vec%0d pwrite", i), {31'd0, bus.pwrite_o}, {31'd0, vecs[i].pwrite});
            chk($sformatf("vec%0d paddr", i), bus.paddr_o, vecs[i].paddr);
            chk($sformatf("vec%0d pwdata", i), bus.pwdata_o, vecs[i].pwdata);
            chk($sformatf("vec%0d rvalid", i), {31'd0, bus.rvalid_o}, {31'd0, vecs[i].rvalid});
            chk($sformatf("vec%0d rdata", i), bus.rdata_o, vecs[i].rdata);
            chk($sformatf("vec%0d err", i), {31'd0, bus.err_o}, {31'd0, vecs[i].err});
            tick();
        end

        // Reset during an ACCESS wait state kills the transfer without a response
        drive(1, 0, B_ADDR, A_DATA, 0, 0, 0);
        #3;
        chk("rst_mid gnt", {31'd0, bus.gnt_o}, 32'd1);
        tick();
        drive(0, 0, B_ADDR, A_DATA, 0, 0, 0);
        tick();
        #3;
        chk("rst_mid access penable", {31'd0, bus.penable_o}, 32'd1);
        tick();
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
        drive(0, 0, 0, 0, 1, RD_B, 0);
        #3;
        chk_all_zero("rst_mid after");
        tick();
        #3;
        chk("rst_mid no rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        tick();
        drive(1, 1, A_ADDR, A_DATA, 1, 0, 0);
        #3;
        chk("post_rst gnt", {31'd0, bus.gnt_o}, 32'd1);
        tick();
        drive(0, 1, A_ADDR, A_DATA, 1, 0, 0);
        #3;
        chk("post_rst setup psel", {31'd0, bus.psel_o}, 32'd1);
        chk("post_rst paddr", bus.paddr_o, A_ADDR);
        tick();
        #3;
        chk("post_rst access penable", {31'd0, bus.penable_o}, 32'd1);
        tick();
        #3;
        chk("post_rst rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        chk("post_rst err", {31'd0, bus.err_o}, 32'd0);
        tick();

`ifdef APB_MASTER_TIMEOUT_EN
        // Abort after the 4th ACCESS cycle without pready
        drive(1, 0, B_ADDR, A_DATA, 0, RD_B, 0);
        #3;
        chk("to gnt", {31'd0, bus.gnt_o}, 32'd1);
        tick();
        drive(0, 0, B_ADDR, A_DATA, 0, RD_B, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) bus.req_i = 1'b1;
            #3;
            chk($sformatf("to access%0d penable", k), {31'd0, bus.penable_o}, 32'd1);
            chk($sformatf("to access%0d rvalid", k), {31'd0, bus.rvalid_o}, 32'd0);
        end
        chk("to no gnt on abort", {31'd0, bus.gnt_o}, 32'd0);
        tick();
        bus.req_i = 1'b0;
        #3;
        chk("to rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        chk("to err", {31'd0, bus.err_o}, 32'd1);
        chk("to rdata", bus.rdata_o, 32'd0);
        chk("to psel idle", {31'd0, bus.psel_o}, 32'd0);
        tick();
        #3;
        chk("to rvalid drop", {31'd0, bus.rvalid_o}, 32'd0);
        tick();
        // pready on the terminal cycle completes normally
        drive(1, 0, B_ADDR, A_DATA, 0, RD_B, 0);
        tick();
        drive(0, 0, B_ADDR, A_DATA, 0, RD_B, 0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 4) bus.pready_i = 1'b1;
        end
        tick();
        bus.pready_i = 1'b0;
        #3;
        chk("to_edge rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        chk("to_edge err", {31'd0, bus.err_o}, 32'd0);
        chk("to_edge rdata", bus.rdata_o, RD_B);
        tick();
`else
        // Without the timeout the ACCESS phase waits indefinitely
        drive(1, 0, B_ADDR, A_DATA, 0, RD_B, 0);
        tick();
        drive(0, 0, B_ADDR, A_DATA, 0, RD_B, 0);
        for (int k = 1; k <= 6; k++) begin
            tick();
        end
        #3;
        chk("nto still access penable", {31'd0, bus.penable_o}, 32'd1);
        chk("nto no rvalid", {31'd0, bus.rvalid_o}, 32'd0);
        bus.pready_i = 1'b1;
        tick();
        bus.pready_i = 1'b0;
        #3;
        chk("nto rvalid", {31'd0, bus.rvalid_o}, 32'd1);
        chk("nto err", {31'd0, bus.err_o}, 32'd0);
        chk("nto rdata", bus.rdata_o, RD_B);
        tick();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
